count_stream_checker: RTL and testbench
=======================================

Name: count_stream_checker

Overview:
Consumer-side checker for the free-running W-bit count stream produced by the team's counter blocks (a <= a+1, synchronous clear to 0). It samples the stream, locks onto the increment sequence and flags slips and skips once locked. It counts wrap-arounds (all-ones -> 0) and errors. It sits beside any counter instance in a bench or on silicon as a health monitor.

Parameters:
W, 3, width of the observed count.
LOCK_N, 4, consecutive correct increments required to declare lock (>=1).
UNLOCK_N, 2, consecutive mismatches while locked that drop lock (>=1).
ERR_W, 8, width of the saturating err_count and wrap_count.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous, active-low reset.
valid  in  1  sample enable; a is examined only when valid=1.
a  in  W  observed count value.
sync_clr  in  1  upstream counter is being cleared this sample; a must equal 0.
locked  out  1  checker locked to the sequence.
err  out  1  one-cycle pulse per error.
expected  out  W  next value the checker predicts ((prev+1) mod 2^W).
err_count  out  ERR_W  saturating error count.
wrap_count  out  ERR_W  saturating count of observed wraps.

Behaviour:
- Reset (rst=0, async): state IDLE; locked=0, err=0, expected=0, err_count=0, wrap_count=0; internal prev, match_cnt and miss_cnt=0. Release is synchronous to the next clk edge.
- All outputs are registered. The response to the sample at edge k is visible after edge k (latency 1).
- valid=0: all state and counters hold; err=0.
- match means a == (prev+1) mod 2^W, or sync_clr=1 and a==0. sync_clr=1 with a!=0 is always a mismatch. After every valid sample, prev=a.
- FSM states IDLE, ACQUIRE, LOCKED, SLIP:
  - IDLE: first valid sample -> ACQUIRE, match_cnt=0, no error.
  - ACQUIRE:
    - match: match_cnt+1; reaching LOCK_N -> LOCKED, locked=1.
    - mismatch: match_cnt=0, no err (errors are reported only in LOCKED and SLIP).
  - LOCKED:
    - match: stay.
    - mismatch: err=1, err_count+1, miss_cnt=1, -> SLIP. locked stays 1.
  - SLIP:
    - match: -> LOCKED, miss_cnt=0.
    - mismatch: err=1, err_count+1, miss_cnt+1; reaching UNLOCK_N -> ACQUIRE, locked=0, match_cnt=0.
- Resync: prev is always updated to the observed a, so a single skip costs exactly one error.
- wrap_count increments on a match with prev=2^W-1 and a=0 in LOCKED or SLIP. A sync_clr match is not a wrap.
- Saturation: err_count and wrap_count stop at 2^ERR_W-1 and never roll over.
- Simultaneous events: sync_clr with a=0 from any state counts as a match. An error and a wrap cannot coincide.
- Reset mid-operation: immediate clear regardless of state or valid.

Decomposition:
- Package count_chk_pkg holds:
  - the state enum typedef (IDLE/ACQUIRE/LOCKED/SLIP, 2 bits);
  - default parameter constants;
  - a function next_count(prev) returning (prev+1) mod 2^W.
- One sub-module, sat_counter: parameter width; inputs clk, rst, inc; output count, saturating. It is instantiated twice, for err_count and wrap_count.

Test Plan:
- Reset release, valid=1, a counts 0,1,2,3,4 -> locked=1 after the edge sampling 4; err never pulses; expected=5.
- Continue locked through 5,6,7,0 -> wrap_count=1. After 16 further samples -> wrap_count=3; err_count=0.
- Locked, feed 2,3,5,6,7 -> single err pulse after sample 5; err_count=1; locked stays 1; returns to LOCKED after sample 6.
- Locked, feed 2,3,6,1,2,3,4,5 -> two err pulses (after 6 and 1); locked=0 after sample 1; err_count=2; locked=1 again after sample 5 (4 matches 1->5).
- Locked at a=4, then a=0 with sync_clr=1 -> no err, locked held, expected=1. Then a=3 with sync_clr=1 -> err=1.
- Drop rst mid-stream between edges -> all outputs 0 immediately. With ERR_W=2 and 5 injected errors while locked -> err_count saturates at 3.

Source files
------------

// File: rtl/count_stream_checker_pkg.sv
// -----------------------------------------------------------------------------
// count_chk_pkg
//
// Shared definitions for the count stream checker:
//   - state_t       : checker FSM state encoding (2 bits)
//   - DEF_*         : default parameter values for count_stream_checker
//   - CNT_MAX_W     : widest count the next_count() helper supports
//   - next_count()  : successor of a count value, modulo 2^width
// -----------------------------------------------------------------------------
package count_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_SLIP    = 2'd3
    } state_t;

    localparam int DEF_W        = 3;
    localparam int DEF_LOCK_N   = 4;
    localparam int DEF_UNLOCK_N = 2;
    localparam int DEF_ERR_W    = 8;

    localparam int CNT_MAX_W    = 32;

    // Successor of prev in a width-bit counter: (prev + 1) mod 2^width.
    // Callers pass the count zero-extended to CNT_MAX_W and truncate the result.
    function automatic logic [CNT_MAX_W-1:0] next_count(
        input logic [CNT_MAX_W-1:0] prev,
        input int                   width
    );
        logic [CNT_MAX_W-1:0] mask;
        mask = '1;
        mask = mask >> (CNT_MAX_W - width);
        return (prev + CNT_MAX_W'(1)) & mask;
    endfunction

endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Up-counter that stops at all-ones instead of rolling over.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset, clears count to 0
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current count, width bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [width-1:0] count
);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples its inputs at the same instant, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + width'(1);
        end
    end

endmodule

// File: rtl/count_stream_checker.sv
// -----------------------------------------------------------------------------
// count_stream_checker
//
// Health monitor for a free-running W-bit counter stream. Locks on after
// LOCK_N consecutive correct increments, reports one error per bad sample
// once locked, drops lock after UNLOCK_N consecutive bad samples, and keeps
// saturating counts of errors and observed wrap-arounds.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   valid       in   sample enable; a/sync_clr only examined when 1
//   a           in   observed count value (W bits)
//   sync_clr    in   upstream counter is being cleared; a must be 0
//   locked      out  checker is locked to the sequence (LOCKED or SLIP)
//   err         out  one-cycle pulse per detected error
//   expected    out  predicted next value, (last a + 1) mod 2^W
//   err_count   out  saturating error count (ERR_W bits)
//   wrap_count  out  saturating count of all-ones -> 0 wraps (ERR_W bits)
//
// All outputs are registered: the response to the sample taken at an edge
// is visible right after that edge.
// -----------------------------------------------------------------------------
module count_stream_checker
    import count_chk_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int LOCK_N   = DEF_LOCK_N,
    parameter int UNLOCK_N = DEF_UNLOCK_N,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [W-1:0]     a,
    input  logic             sync_clr,
    output logic             locked,
    output logic             err,
    output logic [W-1:0]     expected,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count
);

    // match_cnt only needs to hold 0..LOCK_N-1 (reaching LOCK_N moves on),
    // miss_cnt only 0..UNLOCK_N-1 (reaching UNLOCK_N drops lock).
    localparam int MW = (LOCK_N   > 1) ? $clog2(LOCK_N)   : 1;
    localparam int XW = (UNLOCK_N > 1) ? $clog2(UNLOCK_N) : 1;

    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_N - 1);
    localparam logic [XW-1:0] MISS_LAST  = XW'(UNLOCK_N - 1);

    state_t        state, state_d;
    logic [W-1:0]  prev;
    logic [MW-1:0] match_cnt, match_cnt_d;
    logic [XW-1:0] miss_cnt, miss_cnt_d;
    logic          err_d;
    logic          wrap_inc;

    logic [W-1:0]  prev_succ;
    logic [W-1:0]  a_succ;
    logic          match;
    logic          is_wrap;

    assign prev_succ = W'(next_count(CNT_MAX_W'(prev), W));
    assign a_succ    = W'(next_count(CNT_MAX_W'(a), W));

    // A clear sample is judged only against zero; the normal increment rule
    // does not apply to it, so sync_clr with a != 0 is always a mismatch.
    assign match   = sync_clr ? (a == '0) : (a == prev_succ);
    assign is_wrap = !sync_clr && (prev == '1) && (a == '0);

    // -------------------------------------------------------------------------
    // Next-state and output decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state;
        match_cnt_d = match_cnt;
        miss_cnt_d  = miss_cnt;
        err_d       = 1'b0;
        wrap_inc    = 1'b0;

        if (valid) begin
            unique case (state)
                ST_IDLE: begin
                    state_d     = ST_ACQUIRE;
                    match_cnt_d = '0;
                end

                ST_ACQUIRE: begin
                    if (match) begin
                        if (match_cnt == MATCH_LAST) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_cnt + MW'(1);
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end

                ST_LOCKED: begin
                    if (match) begin
                        wrap_inc = is_wrap;
                    end else begin
                        err_d = 1'b1;
                        // With UNLOCK_N == 1 the first miss already drops lock.
                        if (UNLOCK_N == 1) begin
                            state_d     = ST_ACQUIRE;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            state_d    = ST_SLIP;
                            miss_cnt_d = XW'(1);
                        end
                    end
                end

                ST_SLIP: begin
                    if (match) begin
                        state_d    = ST_LOCKED;
                        miss_cnt_d = '0;
                        wrap_inc   = is_wrap;
                    end else begin
                        err_d = 1'b1;
                        if (miss_cnt == MISS_LAST) begin
                            state_d     = ST_ACQUIRE;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            miss_cnt_d = miss_cnt + XW'(1);
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            prev      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            expected  <= '0;
        end else begin
            state     <= state_d;
            match_cnt <= match_cnt_d;
            miss_cnt  <= miss_cnt_d;
            locked    <= (state_d == ST_LOCKED) || (state_d == ST_SLIP);
            err       <= err_d;
            // Always resync to what was observed, so a single skip costs
            // exactly one error rather than a cascade.
            if (valid) begin
                prev     <= a;
                expected <= a_succ;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Saturating statistics; they step on the same edge as err/state.
    // -------------------------------------------------------------------------
    sat_counter #(.width(ERR_W)) u_err_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_d),
        .count (err_count)
    );

    sat_counter #(.width(ERR_W)) u_wrap_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (wrap_inc),
        .count (wrap_count)
    );

endmodule

// File: tb/tb_count_stream_checker.sv
// -----------------------------------------------------------------------------
// tb_count_stream_checker
//
// Directed bench for count_stream_checker. Two instances share the stimulus:
// dut uses default parameters, dut_sat uses ERR_W=2 to exercise saturation.
// Inputs change on the falling edge; outputs are read 1 time unit after the
// rising edge that sampled them.
// -----------------------------------------------------------------------------
module tb_count_stream_checker;

    logic       clk;
    logic       rst;
    logic       valid;
    logic [2:0] a;
    logic       sync_clr;

    logic       locked;
    logic       err;
    logic [2:0] expected;
    logic [7:0] err_count;
    logic [7:0] wrap_count;

    logic       s_locked;
    logic       s_err;
    logic [2:0] s_expected;
    logic [1:0] s_err_count;
    logic [1:0] s_wrap_count;

    int tests_run;
    int tests_failed;

    count_stream_checker #(
        .W(3), .LOCK_N(4), .UNLOCK_N(2), .ERR_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .a          (a),
        .sync_clr   (sync_clr),
        .locked     (locked),
        .err        (err),
        .expected   (expected),
        .err_count  (err_count),
        .wrap_count (wrap_count)
    );

    count_stream_checker #(
        .W(3), .LOCK_N(4), .UNLOCK_N(2), .ERR_W(2)
    ) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .a          (a),
        .sync_clr   (sync_clr),
        .locked     (s_locked),
        .err        (s_err),
        .expected   (s_expected),
        .err_count  (s_err_count),
        .wrap_count (s_wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] val, input logic sc);
        @(negedge clk);
        valid    = v;
        a        = val;
        sync_clr = sc;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] pair_bad  [5] = '{3'd6, 3'd1, 3'd4, 3'd7, 3'd2};
    logic [2:0] pair_good [5] = '{3'd7, 3'd2, 3'd5, 3'd0, 3'd3};

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        valid    = 1'b0;
        a        = '0;
        sync_clr = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked",   locked,     0);
        check("rst_err",      err,        0);
        check("rst_expected", expected,   0);
        check("rst_errcnt",   err_count,  0);
        check("rst_wrapcnt",  wrap_count, 0);

        @(negedge clk);
        rst = 1'b1;

        // ---- acquire on 0..4 ----
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'(i), 1'b0);
            check("acq_err", err, 0);
            check("acq_unlocked", locked, 0);
        end
        step(1'b1, 3'd4, 1'b0);
        check("lock_locked",   locked,   1);
        check("lock_err",      err,      0);
        check("lock_expected", expected, 5);

        // ---- wraps while locked ----
        step(1'b1, 3'd5, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        step(1'b1, 3'd7, 1'b0);
        check("prewrap_cnt", wrap_count, 0);
        step(1'b1, 3'd0, 1'b0);
        check("wrap1_cnt",    wrap_count, 1);
        check("wrap1_locked", locked,     1);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 3'(i % 8), 1'b0);
            check("run_err", err, 0);
        end
        check("wrap3_cnt",   wrap_count, 3);
        check("wrap3_errcnt", err_count, 0);

        // ---- single skip: 1,2,3,5,6,7 ----
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        check("skip_pre_err", err, 0);
        step(1'b1, 3'd5, 1'b0);
        check("skip_err",      err,       1);
        check("skip_errcnt",   err_count, 1);
        check("skip_locked",   locked,    1);
        check("skip_expected", expected,  6);
        step(1'b1, 3'd6, 1'b0);
        check("skip_rec_err",    err,    0);
        check("skip_rec_locked", locked, 1);
        step(1'b1, 3'd7, 1'b0);
        check("skip_after_err", err, 0);

        // ---- double miss drops lock: 0,1,2,3,6,1,2,3,4,5 ----
        step(1'b1, 3'd0, 1'b0);
        check("wrap4_cnt", wrap_count, 4);
        step(1'b1, 3'd1, 1'b0);
        step(1'b1, 3'd2, 1'b0);
        step(1'b1, 3'd3, 1'b0);
        step(1'b1, 3'd6, 1'b0);
        check("miss1_err",    err,       1);
        check("miss1_errcnt", err_count, 2);
        check("miss1_locked", locked,    1);
        step(1'b1, 3'd1, 1'b0);
        check("miss2_err",    err,       1);
        check("miss2_errcnt", err_count, 3);
        check("miss2_locked", locked,    0);
        for (int i = 2; i <= 4; i++) begin
            step(1'b1, 3'(i), 1'b0);
            check("reacq_err",    err,    0);
            check("reacq_locked", locked, 0);
        end
        step(1'b1, 3'd5, 1'b0);
        check("relock_locked", locked,    1);
        check("relock_errcnt", err_count, 3);

        // ---- sync_clr handling ----
        for (int i = 6; i <= 12; i++) begin
            step(1'b1, 3'(i % 8), 1'b0);
        end
        check("wrap5_cnt", wrap_count, 5);
        step(1'b1, 3'd0, 1'b1);
        check("sclr_err",      err,      0);
        check("sclr_locked",   locked,   1);
        check("sclr_expected", expected, 1);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 3'(i), 1'b0);
        end
        step(1'b1, 3'd0, 1'b1);
        check("sclr_nowrap_cnt", wrap_count, 5);
        check("sclr_nowrap_err", err,        0);
        step(1'b1, 3'd3, 1'b1);
        check("sclr_bad_err",    err,       1);
        check("sclr_bad_errcnt", err_count, 4);
        check("sclr_bad_locked", locked,    1);

        // ---- valid=0 holds everything ----
        step(1'b0, 3'd6, 1'b1);
        check("hold_err",      err,       0);
        check("hold_expected", expected,  4);
        check("hold_errcnt",   err_count, 4);
        check("hold_locked",   locked,    1);
        step(1'b1, 3'd4, 1'b0);
        check("hold_resume_err",      err,      0);
        check("hold_resume_expected", expected, 5);

        // ---- asynchronous reset between edges ----
        #2;
        rst = 1'b0;
        #1;
        check("arst_locked",     locked,       0);
        check("arst_err",        err,          0);
        check("arst_expected",   expected,     0);
        check("arst_errcnt",     err_count,    0);
        check("arst_wrapcnt",    wrap_count,   0);
        check("arst_sat_errcnt", s_err_count,  0);
        check("arst_sat_locked", s_locked,     0);
        @(negedge clk);
        rst = 1'b1;

        // ---- saturation: relock, then 5 isolated errors ----
        for (int i = 0; i <= 4; i++) begin
            step(1'b1, 3'(i), 1'b0);
        end
        check("sat_lock", s_locked, 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, pair_bad[i], 1'b0);
            check("sat_bad_err", err, 1);
            step(1'b1, pair_good[i], 1'b0);
            check("sat_good_err", err, 0);
        end
        check("sat_errcnt_wide", err_count,   5);
        check("sat_errcnt_sat",  s_err_count, 3);
        check("sat_locked",      locked,      1);
        check("sat_sat_locked",  s_locked,    1);
        check("sat_wrapcnt",     wrap_count,  1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
